// File: rtl/distribute_1xn_buf_seq.sv
// distribute_1xn_buf_seq
//   Buffered 1-to-NUM_OUT distribute switch for the distribution NoC tree.
//   Each input packet carries a destination mask (i_cmd) that selects one,
//   several or all output channels. Every output channel has its own FIFO
//   and valid/ready handshake, so a stalled consumer only blocks packets
//   that target it. A multicast is accepted into all its FIFOs in one cycle
//   or not at all.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     i_en            switch enable; low freezes all state
//     i_valid/o_ready input handshake
//     i_data_bus      input payload
//     i_cmd           destination mask, bit k -> channel k
//     o_valid/i_ready per-channel output handshake
//     o_data_bus      channel k at [k*DATA_WIDTH +: DATA_WIDTH], zero when empty
//     o_stall_cnt     saturating count of cycles where a valid input was
//                     refused (only when DISTRIBUTE_STALL_CNT_EN is defined)
//
//   Optional feature macro: DISTRIBUTE_STALL_CNT_EN
module distribute_1xn_buf_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DATA_WIDTH-1:0]         i_data_bus,
    input  logic [NUM_OUT-1:0]            i_cmd,
    output logic [NUM_OUT-1:0]            o_valid,
    input  logic [NUM_OUT-1:0]            i_ready,
    output logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus
`ifdef DISTRIBUTE_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]          o_stall_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [NUM_OUT][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [NUM_OUT][FIFO_DEPTH];
    logic [CW-1:0]         cnt_q [NUM_OUT];
    logic [CW-1:0]         cnt_d [NUM_OUT];
    logic [PW-1:0]         wr_q  [NUM_OUT];
    logic [PW-1:0]         wr_d  [NUM_OUT];
    logic [PW-1:0]         rd_q  [NUM_OUT];
    logic [PW-1:0]         rd_d  [NUM_OUT];

    logic                  ready;
    logic [NUM_OUT-1:0]    push;
    logic [NUM_OUT-1:0]    pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // Ready looks only at registered counts; a same-cycle pop never
        // frees a slot, which keeps the i_ready -> o_ready path cut.
        ready = i_en & ~rst;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            if (i_cmd[k] && (cnt_q[k] == CW'(FIFO_DEPTH))) begin
                ready = 1'b0;
            end
        end
    end

    assign o_ready = ready;

    always_comb begin
        mem_d      = mem_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        push       = '0;
        pop        = '0;
        o_valid    = '0;
        o_data_bus = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            o_valid[k] = i_en & ~rst & (cnt_q[k] != '0);
            // Head is shown even while disabled so the data bus holds.
            if (!rst && (cnt_q[k] != '0)) begin
                o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_q[k]];
            end
            push[k] = i_valid & ready & i_cmd[k];
            pop[k]  = o_valid[k] & i_ready[k];
            if (push[k]) begin
                mem_d[k][wr_q[k]] = i_data_bus;
                wr_d[k]           = ptr_inc(wr_q[k]);
            end
            if (pop[k]) begin
                rd_d[k] = ptr_inc(rd_q[k]);
            end
            unique case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
                2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            for (int unsigned k = 0; k < NUM_OUT; k++) begin
                cnt_q[k] <= '0;
                wr_q[k]  <= '0;
                rd_q[k]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

`ifdef DISTRIBUTE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (i_en && i_valid && !ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_distribute_1xn_buf_seq.sv
// Testbench for distribute_1xn_buf_seq: per-channel queue model, checked
// every cycle at the falling edge, plus directed literal expectations.
module tb_distribute_1xn_buf_seq;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int D  = 2;
    localparam int SW = 16;

    logic            clk;
    logic            rst;
    logic            i_en;
    logic            i_valid;
    logic            o_ready;
    logic [DW-1:0]   i_data_bus;
    logic [N-1:0]    i_cmd;
    logic [N-1:0]    o_valid;
    logic [N-1:0]    i_ready;
    logic [N*DW-1:0] o_data_bus;
`ifdef DISTRIBUTE_STALL_CNT_EN
    logic [SW-1:0]   o_stall_cnt;
`endif

    distribute_1xn_buf_seq #(
        .DATA_WIDTH(DW),
        .NUM_OUT   (N),
        .FIFO_DEPTH(D),
        .CNT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (i_en),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data_bus(i_data_bus),
        .i_cmd     (i_cmd),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data_bus(o_data_bus)
`ifdef DISTRIBUTE_STALL_CNT_EN
        ,
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [DW-1:0] dq_t[$];
    dq_t         mq[N];
    int unsigned m_stall;
    int          n_vec;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        if (rst || !i_en) return 1'b0;
        for (int k = 0; k < N; k++) begin
            if (i_cmd[k] && mq[k].size() >= D) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input logic r, input logic en, input logic v,
                         input logic [N-1:0] cmd, input logic [DW-1:0] d,
                         input logic [N-1:0] rdy);
        rst = r; i_en = en; i_valid = v; i_cmd = cmd; i_data_bus = d; i_ready = rdy;
    endtask

    // Compare all outputs against the model in the middle of the cycle.
    task automatic sample();
        logic [N-1:0]  ev;
        logic [DW-1:0] ed;
        @(negedge clk);
        n_vec++;
        check("o_ready", 64'(o_ready), 64'(model_ready()));
        for (int k = 0; k < N; k++) begin
            ev[k] = !rst && i_en && (mq[k].size() != 0);
            ed    = (!rst && mq[k].size() != 0) ? mq[k][0] : '0;
            check($sformatf("o_data_bus[ch%0d]", k), 64'(o_data_bus[k*DW +: DW]), 64'(ed));
        end
        check("o_valid", 64'(o_valid), 64'(ev));
`ifdef DISTRIBUTE_STALL_CNT_EN
        check("o_stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
`endif
    endtask

    // Advance the model across the rising edge using the held inputs.
    task automatic edge_step();
        logic rdy;
        @(posedge clk);
        rdy = model_ready();
        if (rst) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            m_stall = 0;
        end else if (i_en) begin
            if (i_valid && !rdy && m_stall != (1 << SW) - 1) m_stall++;
            for (int k = 0; k < N; k++) begin
                if (mq[k].size() != 0 && i_ready[k]) void'(mq[k].pop_front());
                if (i_valid && rdy && i_cmd[k]) mq[k].push_back(i_data_bus);
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        edge_step();
    endtask

    initial begin
        n_vec = 0; n_fail = 0; m_stall = 0;
        drive(1, 1, 0, '0, '0, '0);
        step(); step();

        // Reset with FIFOs partly full.
        drive(0, 1, 1, 4'hF, 32'h11, 4'h0); step();
        i_data_bus = 32'h22; step();
        rst = 1'b1;
        sample();
        check("rst_cycle_ready", 64'(o_ready), 64'd0);
        check("rst_cycle_valid", 64'(o_valid), 64'd0);
        check("rst_cycle_data", 64'(o_data_bus[63:0]), 64'd0);
        edge_step();
        drive(0, 1, 0, 4'hF, '0, 4'h0);
        sample();
        check("post_rst_valid", 64'(o_valid), 64'd0);
        check("post_rst_ready", 64'(o_ready), 64'd1);
        check("post_rst_data", 64'(o_data_bus[127:64]), 64'd0);
        edge_step();

        // Unicast.
        drive(0, 1, 1, 4'b0001, 32'hA5A5A5A5, 4'hF); step();
        i_valid = 1'b0;
        sample();
        check("uni_valid", 64'(o_valid), 64'b0001);
        check("uni_data", 64'(o_data_bus[31:0]), 64'hA5A5A5A5);
        edge_step();
        sample();
        check("uni_popped", 64'(o_valid), 64'd0);
        edge_step();

        // Broadcast with channel 2 back-pressured.
        drive(0, 1, 1, 4'hF, 32'h1, 4'b1011); step();
        i_data_bus = 32'h2; step();
        i_data_bus = 32'h3;
        sample();
        check("bc_blocked", 64'(o_ready), 64'd0);
        check("bc_ch2_head", 64'(o_data_bus[95:64]), 64'h1);
        edge_step();
        step();
        i_ready = 4'hF;
        sample();
        check("bc_no_bypass", 64'(o_ready), 64'd0);
        edge_step();
        sample();
        check("bc_accept3", 64'(o_ready), 64'd1);
`ifdef DISTRIBUTE_STALL_CNT_EN
        check("bc_stall", 64'(o_stall_cnt), 64'd3);
`endif
        edge_step();
        i_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Disjoint multicast.
        drive(0, 1, 1, 4'b0001, 32'hC0, 4'h0); step();
        i_data_bus = 32'hC1; step();
        i_cmd = 4'b0011; i_data_bus = 32'hC2;
        sample();
        check("dj_blocked", 64'(o_ready), 64'd0);
        edge_step();
        i_cmd = 4'b1100; i_data_bus = 32'hC3;
        sample();
        check("dj_accept", 64'(o_ready), 64'd1);
        edge_step();
        drive(0, 1, 0, '0, '0, 4'hF);
        for (int i = 0; i < 4; i++) step();

        // Enable dropped with one entry per channel.
        drive(0, 1, 1, 4'hF, 32'hE1, 4'h0); step();
        i_valid = 1'b0;
        step();
        i_en = 1'b0; i_ready = 4'hF;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("en_low_valid", 64'(o_valid), 64'd0);
            check("en_low_hold", 64'(o_data_bus[63:32]), 64'hE1);
            edge_step();
        end
        i_en = 1'b1;
        sample();
        check("en_resume", 64'(o_valid), 64'hF);
        edge_step();
        step();

        // Empty mask drop.
        drive(0, 1, 1, 4'b0000, 32'hDEAD, 4'h0);
        sample();
        check("drop_ready", 64'(o_ready), 64'd1);
        edge_step();
        i_valid = 1'b0;
        sample();
        check("drop_no_valid", 64'(o_valid), 64'd0);
        edge_step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) < 7), N'($urandom), $urandom, N'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
